// File: rtl/sram_mbist_march_ctrl.sv
// March C- BIST controller in front of a 512x32 single-port SRAM; optional failure diagnostics under MBIST_DIAG_EN.
// Latency: 10*DEPTH+1 cycles from accepted start to bist_done; no backpressure, and functional traffic is ignored while busy.
module sram_mbist_march_ctrl #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 9,
  parameter logic [DATA_WIDTH-1:0] BACKGROUND = {DATA_WIDTH{1'b0}}
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  bist_start,
  output logic                  bist_busy,
  output logic                  bist_done,
  output logic                  bist_fail,
  input  logic                  func_csb0,
  input  logic                  func_web0,
  input  logic [ADDR_WIDTH-1:0] func_addr0,
  input  logic [DATA_WIDTH-1:0] func_din0,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [DATA_WIDTH-1:0] sram_din0,
  input  logic [DATA_WIDTH-1:0] sram_dout0
`ifdef MBIST_DIAG_EN
  ,
  output logic [ADDR_WIDTH-1:0] diag_fail_addr,
  output logic [2:0]            diag_fail_elem,
  output logic [DATA_WIDTH-1:0] diag_fail_syndrome,
  output logic [15:0]           diag_fail_count
`endif
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = {ADDR_WIDTH{1'b1}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [2:0]            elem_q, elem_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  op_q, op_d;
  logic                  drain_q, drain_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  fail_q, fail_d;
  logic                  csb_q, csb_d;
  logic                  web_q, web_d;
  logic [ADDR_WIDTH-1:0] baddr_q, baddr_d;
  logic [DATA_WIDTH-1:0] bdin_q, bdin_d;
  logic                  s1_vld_q, s1_vld_d, s2_vld_q, s2_vld_d;
  logic [DATA_WIDTH-1:0] s1_exp_q, s1_exp_d, s2_exp_q, s2_exp_d;

  logic                  issue, is_read, invert, down, word_last, addr_end, last_op, miscmp;
  logic [DATA_WIDTH-1:0] op_data;

`ifdef MBIST_DIAG_EN
  logic [ADDR_WIDTH-1:0] s1_addr_q, s1_addr_d, s2_addr_q, s2_addr_d;
  logic [2:0]            s1_elem_q, s1_elem_d, s2_elem_q, s2_elem_d;
  logic [ADDR_WIDTH-1:0] dg_addr_q, dg_addr_d;
  logic [2:0]            dg_elem_q, dg_elem_d;
  logic [DATA_WIDTH-1:0] dg_synd_q, dg_synd_d;
  logic [15:0]           dg_cnt_q, dg_cnt_d;
`endif

  always_comb begin
    state_d  = state_q;
    elem_d   = elem_q;
    addr_d   = addr_q;
    op_d     = op_q;
    drain_d  = drain_q;
    done_d   = done_q;
    fail_d   = fail_q;
    csb_d    = csb_q;
    web_d    = web_q;
    baddr_d  = baddr_q;
    bdin_d   = bdin_q;
    s1_vld_d = 1'b0;
    s1_exp_d = s1_exp_q;
    s2_vld_d = s1_vld_q;
    s2_exp_d = s1_exp_q;
    issue    = 1'b0;

    // (elem_q, addr_q, op_q) always points at the next op to issue.
    is_read   = (elem_q != 3'd0) && !op_q;
    word_last = (elem_q == 3'd0) || (elem_q == 3'd5) || op_q;
    down      = (elem_q == 3'd3) || (elem_q == 3'd4);
    addr_end  = down ? (addr_q == '0) : (addr_q == ADDR_MAX);
    last_op   = (elem_q == 3'd5) && addr_end;
    if ((elem_q == 3'd1) || (elem_q == 3'd3))
      invert = op_q;
    else if ((elem_q == 3'd2) || (elem_q == 3'd4))
      invert = !op_q;
    else
      invert = 1'b0;
    op_data = invert ? ~BACKGROUND : BACKGROUND;

`ifdef MBIST_DIAG_EN
    s1_addr_d = addr_q;
    s1_elem_d = elem_q;
    s2_addr_d = s1_addr_q;
    s2_elem_d = s1_elem_q;
    dg_addr_d = dg_addr_q;
    dg_elem_d = dg_elem_q;
    dg_synd_d = dg_synd_q;
    dg_cnt_d  = dg_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bist_start) begin
          issue   = 1'b1;
          state_d = S_RUN;
          done_d  = 1'b0;
          fail_d  = 1'b0;
`ifdef MBIST_DIAG_EN
          dg_addr_d = '0;
          dg_elem_d = '0;
          dg_synd_d = '0;
          dg_cnt_d  = '0;
`endif
        end
      end
      S_RUN: begin
        issue = 1'b1;
        if (last_op) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end
      end
      S_DRAIN: begin
        csb_d   = 1'b1;
        web_d   = 1'b1;
        drain_d = 1'b1;
        if (drain_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (issue) begin
      csb_d    = 1'b0;
      web_d    = is_read;
      baddr_d  = addr_q;
      bdin_d   = op_data;
      s1_vld_d = is_read;
      s1_exp_d = op_data;
      if (!word_last) begin
        op_d = 1'b1;
      end else begin
        op_d = 1'b0;
        if (last_op) begin
          elem_d = '0;
          addr_d = '0;
        end else if (!addr_end) begin
          addr_d = down ? addr_q - 1'b1 : addr_q + 1'b1;
        end else begin
          elem_d = elem_q + 3'd1;
          addr_d = ((elem_q == 3'd2) || (elem_q == 3'd3)) ? ADDR_MAX : '0;
        end
      end
    end

    // Case inequality so an X on the read bus also counts as a miscompare in simulation.
    miscmp = s2_vld_q && (sram_dout0 !== s2_exp_q);
    if (miscmp) begin
      fail_d = 1'b1;
`ifdef MBIST_DIAG_EN
      if (dg_cnt_q == 16'h0000) begin
        dg_addr_d = s2_addr_q;
        dg_elem_d = s2_elem_q;
        dg_synd_d = sram_dout0 ^ s2_exp_q;
      end
      if (dg_cnt_q != 16'hFFFF)
        dg_cnt_d = dg_cnt_q + 16'd1;
`endif
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      state_q  <= S_IDLE;
      elem_q   <= '0;
      addr_q   <= '0;
      op_q     <= 1'b0;
      drain_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      fail_q   <= 1'b0;
      csb_q    <= 1'b1;
      web_q    <= 1'b1;
      baddr_q  <= '0;
      bdin_q   <= '0;
      s1_vld_q <= 1'b0;
      s1_exp_q <= '0;
      s2_vld_q <= 1'b0;
      s2_exp_q <= '0;
`ifdef MBIST_DIAG_EN
      s1_addr_q <= '0;
      s1_elem_q <= '0;
      s2_addr_q <= '0;
      s2_elem_q <= '0;
      dg_addr_q <= '0;
      dg_elem_q <= '0;
      dg_synd_q <= '0;
      dg_cnt_q  <= '0;
`endif
    end else begin
      state_q  <= state_d;
      elem_q   <= elem_d;
      addr_q   <= addr_d;
      op_q     <= op_d;
      drain_q  <= drain_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      fail_q   <= fail_d;
      csb_q    <= csb_d;
      web_q    <= web_d;
      baddr_q  <= baddr_d;
      bdin_q   <= bdin_d;
      s1_vld_q <= s1_vld_d;
      s1_exp_q <= s1_exp_d;
      s2_vld_q <= s2_vld_d;
      s2_exp_q <= s2_exp_d;
`ifdef MBIST_DIAG_EN
      s1_addr_q <= s1_addr_d;
      s1_elem_q <= s1_elem_d;
      s2_addr_q <= s2_addr_d;
      s2_elem_q <= s2_elem_d;
      dg_addr_q <= dg_addr_d;
      dg_elem_q <= dg_elem_d;
      dg_synd_q <= dg_synd_d;
      dg_cnt_q  <= dg_cnt_d;
`endif
    end
  end

  assign bist_busy  = busy_q;
  assign bist_done  = done_q;
  assign bist_fail  = fail_q;
  assign sram_csb0  = busy_q ? csb_q   : func_csb0;
  assign sram_web0  = busy_q ? web_q   : func_web0;
  assign sram_addr0 = busy_q ? baddr_q : func_addr0;
  assign sram_din0  = busy_q ? bdin_q  : func_din0;

`ifdef MBIST_DIAG_EN
  assign diag_fail_addr     = dg_addr_q;
  assign diag_fail_elem     = dg_elem_q;
  assign diag_fail_syndrome = dg_synd_q;
  assign diag_fail_count    = dg_cnt_q;
`endif

endmodule

// File: tb/tb_sram_mbist_march_ctrl.sv
// Directed bench for sram_mbist_march_ctrl with a behavioural 512x32 SRAM and read-data fault injection.
module tb_sram_mbist_march_ctrl;

  logic        clk0 = 1'b0;
  logic        rst0;
  logic        bist_start;
  logic        bist_busy, bist_done, bist_fail;
  logic        func_csb0, func_web0;
  logic [8:0]  func_addr0;
  logic [31:0] func_din0;
  logic        sram_csb0, sram_web0;
  logic [8:0]  sram_addr0;
  logic [31:0] sram_din0;
  logic [31:0] sram_dout0;
`ifdef MBIST_DIAG_EN
  logic [8:0]  diag_fail_addr;
  logic [2:0]  diag_fail_elem;
  logic [31:0] diag_fail_syndrome;
  logic [15:0] diag_fail_count;
`endif

  int tests_run = 0;
  int tests_failed = 0;
  int fault_mode = 0;

  always #5 clk0 = ~clk0;

  sram_mbist_march_ctrl dut (
    .clk0       (clk0),
    .rst0       (rst0),
    .bist_start (bist_start),
    .bist_busy  (bist_busy),
    .bist_done  (bist_done),
    .bist_fail  (bist_fail),
    .func_csb0  (func_csb0),
    .func_web0  (func_web0),
    .func_addr0 (func_addr0),
    .func_din0  (func_din0),
    .sram_csb0  (sram_csb0),
    .sram_web0  (sram_web0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_dout0 (sram_dout0)
`ifdef MBIST_DIAG_EN
    ,
    .diag_fail_addr     (diag_fail_addr),
    .diag_fail_elem     (diag_fail_elem),
    .diag_fail_syndrome (diag_fail_syndrome),
    .diag_fail_count    (diag_fail_count)
`endif
  );

  // Behavioural SRAM: capture on the edge, read data held until the next read.
  logic [31:0] mem [0:511];
  logic [31:0] mem_dout = '0;
  logic [8:0]  rd_addr = '0;

  always @(posedge clk0) begin
    if (!sram_csb0) begin
      if (!sram_web0) begin
        mem[sram_addr0] <= sram_din0;
      end else begin
        mem_dout <= mem[sram_addr0];
        rd_addr  <= sram_addr0;
      end
    end
  end

  always_comb begin
    sram_dout0 = mem_dout;
    if (fault_mode == 1 && rd_addr == 9'h005) sram_dout0[3] = ~mem_dout[3];
    if (fault_mode == 2) sram_dout0[0] = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Sample i is taken 1 time unit after edge E0+i, where E0 accepts the start.
  task automatic run_bist(input int poke_at, input int abort_at,
                          output int busy_n, output int csb_n, output int fail_at);
    busy_n  = 0;
    csb_n   = 0;
    fail_at = -1;
    bist_start = 1'b1;
    @(posedge clk0); #1;
    bist_start = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      if (!bist_busy) break;
      busy_n++;
      if (!sram_csb0) csb_n++;
      if (bist_fail && fail_at < 0) fail_at = i;
      if (i == abort_at) break;
      bist_start = (i == poke_at);
      @(posedge clk0); #1;
    end
    bist_start = 1'b0;
  endtask

  int busy_n, csb_n, fail_at;

  initial begin
    rst0       = 1'b1;
    bist_start = 1'b0;
    func_csb0  = 1'b1;
    func_web0  = 1'b1;
    func_addr0 = 9'h0AB;
    func_din0  = 32'h0;
    #12;
    chk("rst_busy", {31'd0, bist_busy}, 32'd0);
    chk("rst_done", {31'd0, bist_done}, 32'd0);
    chk("rst_fail", {31'd0, bist_fail}, 32'd0);
    chk("rst_pass_addr", {23'd0, sram_addr0}, 32'h0AB);
    chk("rst_pass_csb", {31'd0, sram_csb0}, 32'd1);
    @(posedge clk0); #1;
    rst0 = 1'b0;

    // Idle pass-through write then read.
    func_csb0  = 1'b0;
    func_web0  = 1'b0;
    func_addr0 = 9'h1A0;
    func_din0  = 32'hDEADBEEF;
    #1;
    chk("pt_csb", {31'd0, sram_csb0}, 32'd0);
    chk("pt_web", {31'd0, sram_web0}, 32'd0);
    chk("pt_addr", {23'd0, sram_addr0}, 32'h1A0);
    chk("pt_din", sram_din0, 32'hDEADBEEF);
    @(posedge clk0); #1;
    func_web0 = 1'b1;
    #1;
    chk("pt_web_rd", {31'd0, sram_web0}, 32'd1);
    @(posedge clk0); #1;
    chk("pt_dout", sram_dout0, 32'hDEADBEEF);

    // Functional traffic stays asserted during runs; it must not reach the SRAM.
    func_csb0  = 1'b0;
    func_web0  = 1'b0;
    func_addr0 = 9'h0AB;
    func_din0  = 32'h12345678;

    fault_mode = 0;
    run_bist(-1, -1, busy_n, csb_n, fail_at);
    chk("clean_busy_cycles", busy_n, 32'd5121);
    chk("clean_csb_cycles", csb_n, 32'd5120);
    chk("clean_done", {31'd0, bist_done}, 32'd1);
    chk("clean_fail", {31'd0, bist_fail}, 32'd0);
    repeat (3) @(posedge clk0);
    #1;

    fault_mode = 1;
    run_bist(-1, -1, busy_n, csb_n, fail_at);
    chk("bit3_busy_cycles", busy_n, 32'd5121);
    chk("bit3_done", {31'd0, bist_done}, 32'd1);
    chk("bit3_fail", {31'd0, bist_fail}, 32'd1);
    chk("bit3_fail_at", fail_at, 32'd524);
`ifdef MBIST_DIAG_EN
    chk("bit3_diag_addr", {23'd0, diag_fail_addr}, 32'h005);
    chk("bit3_diag_elem", {29'd0, diag_fail_elem}, 32'd1);
    chk("bit3_diag_synd", diag_fail_syndrome, 32'h00000008);
    chk("bit3_diag_count", {16'd0, diag_fail_count}, 32'd5);
`endif

    fault_mode = 2;
    run_bist(-1, -1, busy_n, csb_n, fail_at);
    chk("sa1_fail", {31'd0, bist_fail}, 32'd1);
    chk("sa1_fail_at", fail_at, 32'd514);
`ifdef MBIST_DIAG_EN
    chk("sa1_diag_addr", {23'd0, diag_fail_addr}, 32'h000);
    chk("sa1_diag_elem", {29'd0, diag_fail_elem}, 32'd1);
    chk("sa1_diag_synd", diag_fail_syndrome, 32'h00000001);
    chk("sa1_diag_count", {16'd0, diag_fail_count}, 32'd1536);
`endif

    // Start pulse mid-run is ignored; accepted start clears the previous fail.
    fault_mode = 0;
    run_bist(100, -1, busy_n, csb_n, fail_at);
    chk("poke_busy_cycles", busy_n, 32'd5121);
    chk("poke_done", {31'd0, bist_done}, 32'd1);
    chk("poke_fail", {31'd0, bist_fail}, 32'd0);

    // Reset in the middle of a failing run.
    fault_mode = 2;
    run_bist(-1, 2000, busy_n, csb_n, fail_at);
    chk("abort_busy_pre", {31'd0, bist_busy}, 32'd1);
    chk("abort_fail_pre", {31'd0, bist_fail}, 32'd1);
    rst0 = 1'b1;
    #1;
    chk("abort_busy", {31'd0, bist_busy}, 32'd0);
    chk("abort_done", {31'd0, bist_done}, 32'd0);
    chk("abort_fail", {31'd0, bist_fail}, 32'd0);
    chk("abort_pass_addr", {23'd0, sram_addr0}, 32'h0AB);
    chk("abort_pass_din", sram_din0, 32'h12345678);
    chk("abort_pass_csb", {31'd0, sram_csb0}, 32'd0);
`ifdef MBIST_DIAG_EN
    chk("abort_diag_count", {16'd0, diag_fail_count}, 32'd0);
`endif
    @(posedge clk0); #1;
    rst0 = 1'b0;
    fault_mode = 0;
    @(posedge clk0); #1;
    run_bist(-1, -1, busy_n, csb_n, fail_at);
    chk("rerun_busy_cycles", busy_n, 32'd5121);
    chk("rerun_csb_cycles", csb_n, 32'd5120);
    chk("rerun_done", {31'd0, bist_done}, 32'd1);
    chk("rerun_fail", {31'd0, bist_fail}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sram_mbist_march_ctrl.md
Name: sram_mbist_march_ctrl

Overview:
- Memory BIST controller sitting directly upstream of the 512x32 single-port OpenRAM macro (csb0/web0/addr0/din0/dout0 interface).
- Runs a March C- sequence over every word, compares read data, and reports pass/fail.
- When idle, passes functional traffic straight through to the macro pins.
- bist_start, bist_done and bist_fail are later driven and observed by the IEEE 1500 wrapper.

Parameters:
- DATA_WIDTH, 32, SRAM word width.
- ADDR_WIDTH, 9, SRAM address width; DEPTH = 1<<ADDR_WIDTH.
- BACKGROUND, {DATA_WIDTH{1'b0}}, data pattern "0". Pattern "1" = ~BACKGROUND.

Ports:
- clk0  in  1  clock, same clock as the SRAM clk0
- rst0  in  1  asynchronous, active-high reset
- bist_start  in  1  one-cycle request; sampled only in IDLE
- bist_busy  out  1  high while in RUN or DRAIN
- bist_done  out  1  sticky; set at test end, cleared by next accepted start or by reset
- bist_fail  out  1  sticky; set on any miscompare, cleared by accepted start or by reset
- func_csb0  in  1  functional chip select, active low
- func_web0  in  1  functional write enable, active low
- func_addr0  in  ADDR_WIDTH  functional address
- func_din0  in  DATA_WIDTH  functional write data
- sram_csb0  out  1  to SRAM csb0
- sram_web0  out  1  to SRAM web0
- sram_addr0  out  ADDR_WIDTH  to SRAM addr0
- sram_din0  out  DATA_WIDTH  to SRAM din0
- sram_dout0  in  DATA_WIDTH  from SRAM dout0

Behaviour:
- Clocking and reset: one clock, clk0. rst0 is asynchronous and active-high.
- Reset: state=IDLE. Internal BIST regs: csb=1, web=1, addr=0, din=0. bist_busy=0, bist_done=0, bist_fail=0. Expected-data pipeline cleared.
- Pin mux: bist_busy=0 → sram_* = func_* (combinational). bist_busy=1 → sram_* = BIST regs; functional inputs ignored.
- States:
  - IDLE → RUN on the edge sampling bist_start=1. That same edge clears done/fail and loads the first op (element 0, addr 0).
  - RUN issues one op per cycle; csb=0 every RUN cycle.
  - RUN → DRAIN after the last op is loaded.
  - DRAIN lasts 2 cycles, BIST csb=1 (no ops), then → IDLE with bist_done=1.
- March C- elements, in order; E = element, addr direction, ops per word:
  - E0: up, w0
  - E1: up, r0, w1
  - E2: up, r1, w0
  - E3: down, r0, w1
  - E4: down, r1, w0
  - E5: up, r0
  - "up" runs 0..DEPTH-1; "down" runs DEPTH-1..0. Address wraps to the next element's start.
  - Total 10*DEPTH ops, with no gap cycles between elements.
- Read latency:
  - An op driven after edge k is captured by the SRAM at edge k+1.
  - Read data is valid before edge k+2, and is compared at edge k+2.
  - Expected data and a read-valid flag pass through a 2-stage pipeline.
- Compare: at a valid-read edge, if sram_dout0 != expected (including any X, via case-inequality semantics in simulation), set bist_fail.
- Timing: with E0 = edge accepting start, the last compare happens at E0+10*DEPTH+1. bist_done rises at that same edge (E0+5121 for DEPTH=512); bist_busy falls there too.
- bist_start while busy: ignored, no restart.
- rst0 mid-run: immediate return to IDLE with reset values; sram_* switch back to func_* asynchronously.

Optional Feature:
- Macro MBIST_DIAG_EN.
- Defined:
  - Adds outputs diag_fail_addr[ADDR_WIDTH], diag_fail_elem[3], diag_fail_syndrome[DATA_WIDTH] (= dout XOR expected) and diag_fail_count[16] (saturating at 16'hFFFF).
  - The first miscompare since start latches addr/elem/syndrome; later fails only increment the count.
  - All diag outputs reset to 0 and clear on accepted start.
- Undefined: these ports and registers are absent; only bist_fail is reported.

Test Plan:
- Fault-free SRAM, pulse bist_start → bist_busy=1 for exactly 5121 cycles, bist_done=1, bist_fail=0, with exactly 5120 csb=0 cycles observed at the SRAM.
- Bench XORs bit 3 of sram_dout0 on reads of addr 9'h005 → bist_fail=1. With MBIST_DIAG_EN: diag_fail_addr=9'h005, elem=1, syndrome=32'h00000008, count=5.
- Bench forces bit 0 of sram_dout0 to 1 (stuck-at-1) on all reads → fail set at the first E1 read of addr 0. With MBIST_DIAG_EN: count=1536 (3*512 r0 reads).
- Idle pass-through: drive func write addr 9'h1A0 data 32'hDEADBEEF, then a read → sram pins mirror func_*; the next-cycle dout0 reads 32'hDEADBEEF.
- Assert rst0 at cycle 2000 of a run → busy/done/fail=0 immediately and sram_* follow func_*. A new start then completes a full 5121-cycle pass.
- Pulse bist_start at cycle 100 of a run → ignored; done still arrives at cycle 5121 after the original start.
